// File: rtl/nec_pkg.sv
// Shared types and constants for the execution-unit sequencers.
// Quotient limits are used to range-check the 32-bit divider result against the op width.
package nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        CHECK,
        RESP
    } div_state_t;

    localparam logic        [31:0] BYTE_UMAX = 32'h0000_00FF;
    localparam logic        [31:0] WORD_UMAX = 32'h0000_FFFF;
    localparam logic signed [31:0] BYTE_SMIN = -32'sd128;
    localparam logic signed [31:0] BYTE_SMAX = 32'sd127;
    localparam logic signed [31:0] WORD_SMIN = -32'sd32768;
    localparam logic signed [31:0] WORD_SMAX = 32'sd32767;

endpackage

// File: rtl/div_sequencer.sv
// Sequences the shared 32-bit divider for DIV/DIVU byte and word ops: packs operands,
// starts the divider, waits (with watchdog) and range-checks the quotient.
module div_sequencer
    import nec_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        req,
    input  logic        wide,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        resp,
    output logic        div_error,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic        dv_start,
    output logic        dv_signed,
    output logic [31:0] dv_num,
    output logic [31:0] dv_denom,
    input  logic        dv_done,
    input  logic [31:0] dv_quot,
    input  logic [31:0] dv_rem
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    div_state_t    state, state_nx;
    logic          op_wide, op_signed, done_seen;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   q_cap;
    logic [15:0]   r_cap;
    logic [31:0]   num_ext, denom_ext;
    logic          denom_zero, tmo_hit, q_ovf, done_any;
    logic          unused_rem_hi;

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic s);
        return s ? {{16{v[15]}}, v} : {16'h0000, v};
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic s);
        return s ? {{24{v[7]}}, v} : {24'h000000, v};
    endfunction

    function automatic logic quot_ovf(input logic [31:0] q, input logic w, input logic s);
        logic signed [31:0] qs;
        qs = $signed(q);
        if (s)
            return w ? (qs < WORD_SMIN || qs > WORD_SMAX) : (qs < BYTE_SMIN || qs > BYTE_SMAX);
        return w ? (q > WORD_UMAX) : (q > BYTE_UMAX);
    endfunction

    assign num_ext       = wide ? dividend : ext16(dividend[15:0], is_signed);
    assign denom_ext     = wide ? ext16(divisor, is_signed) : ext8(divisor[7:0], is_signed);
    assign denom_zero    = (denom_ext == 32'h0);
    assign tmo_hit       = (tmo_cnt == TMO_LAST);
    assign q_ovf         = quot_ovf(q_cap, op_wide, op_signed);
    assign done_any      = done_seen | dv_done;
    assign unused_rem_hi = ^dv_rem[31:16];

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (ce)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        dv_start = 1'b0;
        busy     = (state != IDLE);
        resp     = (state == RESP);
        case (state)
            IDLE:    if (req) state_nx = denom_zero ? RESP : ISSUE;
            // Gate with ce so the divider sees exactly one start sample.
            ISSUE: begin
                dv_start = ce;
                state_nx = ARM;
            end
            ARM:     state_nx = WAIT;
            WAIT: begin
                if (done_any)
                    state_nx = CHECK;
                else if (tmo_hit)
                    state_nx = RESP;
            end
            CHECK:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_wide   <= 1'b0;
            op_signed <= 1'b0;
            done_seen <= 1'b0;
            tmo_cnt   <= '0;
            q_cap     <= '0;
            r_cap     <= '0;
            div_error <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            dv_signed <= 1'b0;
            dv_num    <= '0;
            dv_denom  <= '0;
        end else begin
            // Divider completion can arrive while ce is low; remember it.
            if (state == WAIT && dv_done)
                done_seen <= 1'b1;
            if (ce) begin
                case (state)
                    IDLE: if (req) begin
                        op_wide   <= wide;
                        op_signed <= is_signed;
                        div_error <= denom_zero;
                        if (!denom_zero) begin
                            dv_num    <= num_ext;
                            dv_denom  <= denom_ext;
                            dv_signed <= is_signed;
                        end
                    end
                    ARM: begin
                        tmo_cnt   <= '0;
                        done_seen <= 1'b0;
                    end
                    WAIT: begin
                        if (done_any) begin
                            q_cap <= dv_quot;
                            r_cap <= dv_rem[15:0];
                        end else if (tmo_hit)
                            div_error <= 1'b1;
                        else
                            tmo_cnt <= tmo_cnt + TW'(1);
                    end
                    CHECK: begin
                        div_error <= q_ovf;
                        if (!q_ovf) begin
                            quot <= op_wide ? q_cap[15:0] : {8'h00, q_cap[7:0]};
                            rem  <= op_wide ? r_cap       : {8'h00, r_cap[7:0]};
                        end
                    end
                    RESP:    div_error <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, multi-cycle corner
// sequences and randomized ops checked against an arithmetic reference model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1, ce = 1'b1, req = 1'b0, wide = 1'b0, is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, resp, div_error, dv_start, dv_signed;
    logic [15:0] quot, rem;
    logic [31:0] dv_num, dv_denom;
    logic        dv_done = 1'b1;
    logic [31:0] dv_quot = '0, dv_rem = '0;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    div_sequencer #(.TIMEOUT(63)) dut (
        .clk(clk), .reset(reset), .ce(ce), .req(req), .wide(wide), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .resp(resp),
        .div_error(div_error), .quot(quot), .rem(rem), .dv_start(dv_start),
        .dv_signed(dv_signed), .dv_num(dv_num), .dv_denom(dv_denom), .dv_done(dv_done),
        .dv_quot(dv_quot), .dv_rem(dv_rem)
    );

    // Divider model: done falls on the start edge, rises div_lat edges later.
    int          div_lat = 3;
    bit          hang = 1'b0;
    int          busy_cnt = 0, n_start = 0, n_resp = 0;
    logic [31:0] seen_num = '0, seen_denom = '0;
    logic        seen_signed = 1'b0;

    function automatic logic [63:0] div_fn(input logic [31:0] n, input logic [31:0] d, input logic s);
        longint ln, ld, lq, lr;
        ln = s ? longint'($signed(n)) : longint'(n);
        ld = s ? longint'($signed(d)) : longint'(d);
        if (ld == 0) return '1;
        lq = ln / ld;
        lr = ln % ld;
        return {lq[31:0], lr[31:0]};
    endfunction

    always @(posedge clk) begin
        if (dv_start) begin
            {dv_quot, dv_rem} <= div_fn(dv_num, dv_denom, dv_signed);
            dv_done     <= 1'b0;
            busy_cnt    <= div_lat;
            n_start     <= n_start + 1;
            seen_num    <= dv_num;
            seen_denom  <= dv_denom;
            seen_signed <= dv_signed;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1 && !hang) dv_done <= 1'b1;
        end
    end

    always @(posedge clk)
        if (resp && ce && !reset) n_resp <= n_resp + 1;

    bit ce_tog = 1'b0;
    initial forever begin
        @(negedge clk);
        if (ce_tog) ce = ~ce;
        else        ce = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: instruction semantics with plain integer arithmetic.
    logic [15:0] ref_q = '0, ref_r = '0;

    task automatic ref_op(input logic w, input logic s, input logic [31:0] dvd, input logic [15:0] dvs,
                          output logic err, output logic [31:0] en, output logic [31:0] ed, output bit z);
        longint n, d, q, r;
        if (w) begin
            n = s ? longint'($signed(dvd)) : longint'(dvd);
            d = s ? longint'($signed(dvs)) : longint'(dvs);
        end else begin
            n = s ? longint'($signed(dvd[15:0])) : longint'(dvd[15:0]);
            d = s ? longint'($signed(dvs[7:0])) : longint'(dvs[7:0]);
        end
        en = n[31:0];
        ed = d[31:0];
        z  = (d == 0);
        if (z) begin
            err = 1'b1;
            return;
        end
        q = n / d;
        r = n % d;
        if (w) err = s ? (q < -32768 || q > 32767) : (q > 65535);
        else   err = s ? (q < -128 || q > 127) : (q > 255);
        if (!err) begin
            ref_q = w ? q[15:0] : {8'h00, q[7:0]};
            ref_r = w ? r[15:0] : {8'h00, r[7:0]};
        end
    endtask

    task automatic run_op(input logic w, input logic s, input logic [31:0] dvd, input logic [15:0] dvs,
                          input int lat, output logic a_err, output logic [15:0] a_q, output logic [15:0] a_r,
                          output int a_lat, output int a_drop, output logic e_err, output bit z);
        logic [31:0] en, ed;
        int st0, rs0, n;
        ref_op(w, s, dvd, dvs, e_err, en, ed, z);
        div_lat = lat;
        st0 = n_start;
        rs0 = n_resp;
        @(negedge clk);
        wide = w; is_signed = s; dividend = dvd; divisor = dvs; req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) req = 1'b0;
        end while (!resp && n < 2000);
        req = 1'b0;
        chk("resp_seen", resp, 1'b1);
        a_err = div_error; a_q = quot; a_r = rem; a_lat = n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        a_drop = n;
        chk("busy_drop", busy, 1'b0);
        chk("resp_count", n_resp - rs0, 1);
        chk("start_count", n_start - st0, z ? 0 : 1);
        if (!z) begin
            chk("dv_num", seen_num, en);
            chk("dv_denom", seen_denom, ed);
            chk("dv_signed", seen_signed, s);
        end
    endtask

    typedef struct {
        logic        w, s;
        logic [31:0] dvd;
        logic [15:0] dvs;
        int          lat;
        logic        err;
        logic [15:0] q, r;
        int          elat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic        a_err, e_err;
        logic [15:0] a_q, a_r, sq, sr;
        int          a_lat, a_drop, rs0;
        bit          z;

        // Divide-by-zero responds the cycle after req (elat=1); otherwise 4 + divider run time.
        tbl[0]  = '{1'b0, 1'b0, 32'h0000_0064, 16'h0007, 3, 1'b0, 16'h000E, 16'h0002, 7};
        tbl[1]  = '{1'b1, 1'b1, 32'hFFFF_FF9C, 16'h0007, 5, 1'b0, 16'hFFF2, 16'hFFFE, 9};
        tbl[2]  = '{1'b0, 1'b0, 32'h0000_0200, 16'h0001, 2, 1'b1, 16'hFFF2, 16'hFFFE, 6};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_FF80, 16'h0001, 1, 1'b0, 16'h0080, 16'h0000, 5};
        tbl[4]  = '{1'b1, 1'b0, 32'h1234_5678, 16'h0000, 3, 1'b1, 16'h0080, 16'h0000, 1};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_FF80, 16'h00FF, 2, 1'b1, 16'h0080, 16'h0000, 6};
        tbl[6]  = '{1'b1, 1'b1, 32'h8000_0000, 16'hFFFF, 4, 1'b1, 16'h0080, 16'h0000, 8};
        tbl[7]  = '{1'b1, 1'b0, 32'h0001_0000, 16'h0001, 1, 1'b1, 16'h0080, 16'h0000, 5};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_FFFF, 16'h0001, 1, 1'b0, 16'hFFFF, 16'h0000, 5};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_FF9C, 16'h0007, 6, 1'b0, 16'h00F2, 16'h00FE, 10};
        tbl[10] = '{1'b0, 1'b0, 32'h0000_1234, 16'hFF00, 2, 1'b1, 16'h00F2, 16'h00FE, 1};
        tbl[11] = '{1'b1, 1'b1, 32'h0000_0064, 16'hFFF9, 2, 1'b0, 16'hFFF2, 16'h0002, 6};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);      chk("rst_resp", resp, 0);
        chk("rst_err", div_error, 0);  chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);        chk("rst_start", dv_start, 0);
        chk("rst_signed", dv_signed, 0);
        chk("rst_num", dv_num, 0);     chk("rst_denom", dv_denom, 0);

        foreach (tbl[i]) begin
            run_op(tbl[i].w, tbl[i].s, tbl[i].dvd, tbl[i].dvs, tbl[i].lat,
                   a_err, a_q, a_r, a_lat, a_drop, e_err, z);
            chk("tbl_err", a_err, tbl[i].err);
            chk("tbl_quot", a_q, tbl[i].q);
            chk("tbl_rem", a_r, tbl[i].r);
            chk("tbl_latency", a_lat, tbl[i].elat);
            chk("tbl_busy_fall", a_drop, 1);
        end

        // ce toggling through a whole word divide.
        ce_tog = 1'b1;
        run_op(1'b1, 1'b0, 32'h0001_2345, 16'h0100, 4, a_err, a_q, a_r, a_lat, a_drop, e_err, z);
        chk("ce_err", a_err, 1'b0);
        chk("ce_quot", a_q, 16'h0123);
        chk("ce_rem", a_r, 16'h0045);

        // Reset while waiting on a slow divider; the abandoned op must never respond.
        rs0 = n_resp;
        div_lat = 40;
        @(negedge clk);
        wide = 1'b1; is_signed = 1'b0; dividend = 32'h0000_1000; divisor = 16'h0010; req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) req = 1'b0;
        end
        req = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        ce_tog = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        ref_q = '0; ref_r = '0;
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_quot", quot, 16'h0000);
        run_op(1'b0, 1'b0, 32'h0000_0009, 16'h0003, 3, a_err, a_q, a_r, a_lat, a_drop, e_err, z);
        chk("post_reset_quot", a_q, 16'h0003);
        chk("post_reset_rem", a_r, 16'h0000);
        chk("post_reset_err", a_err, 1'b0);
        chk("reset_one_resp", n_resp - rs0, 1);

        // Watchdog: divider never completes.
        hang = 1'b1;
        sq = ref_q; sr = ref_r;
        run_op(1'b1, 1'b0, 32'h0000_0064, 16'h0007, 5, a_err, a_q, a_r, a_lat, a_drop, e_err, z);
        ref_q = sq; ref_r = sr;
        chk("tmo_err", a_err, 1'b1);
        chk("tmo_latency", a_lat, 66);
        chk("tmo_busy_fall", a_drop, 1);
        chk("tmo_quot", a_q, sq);
        chk("tmo_rem", a_r, sr);
        hang = 1'b0;

        for (int i = 0; i < 150; i++) begin
            logic        w, s;
            logic [31:0] dvd;
            logic [15:0] dvs;
            int          lat;
            w   = 1'($urandom);
            s   = 1'($urandom);
            dvd = 32'($signed($urandom) >>> $urandom_range(0, 31));
            dvs = 16'($signed(16'($urandom)) >>> $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) dvs = '0;
            lat = $urandom_range(1, 8);
            run_op(w, s, dvd, dvs, lat, a_err, a_q, a_r, a_lat, a_drop, e_err, z);
            chk("rnd_err", a_err, e_err);
            chk("rnd_quot", a_q, ref_q);
            chk("rnd_rem", a_r, ref_r);
            chk("rnd_latency", a_lat, z ? 1 : lat + 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
